// File: rtl/reglist_sequencer.sv
// -----------------------------------------------------------------------------
// reglist_sequencer
//   Multi-register transfer engine for LDM/STM-class instructions. On start it
//   captures the instruction fields and then walks the 16-bit register list in
//   ascending order, one register per cycle:
//     STM: reads the register file and writes the word to data memory.
//     LDM: reads data memory and writes the word to the register file
//          (R15 goes to the PC load port instead).
//   A final WB cycle optionally writes the updated base back, then the block
//   returns to IDLE. The controller stalls fetch while busy is high.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           launch a transfer (sampled only in IDLE)
//   is_load/up/pre  LDM vs STM, increment vs decrement, pre vs post index
//   writeback       write the final base value to base_reg
//   base_reg, base  base register number and base address value
//   reglist         bit i set = transfer Ri
//   rf_rd           register-file read data for rf_ra (combinational)
//   mem_rdata       data-memory read data for mem_addr (combinational)
//   rf_ra           register-file read address (STM)
//   rf_we/wa/wd     register-file write port (LDM R0-R14, base writeback)
//   pc_we/pc_wd     PC load port (LDM with R15 in the list)
//   mem_addr        data-memory byte address
//   mem_we/mem_wdata data-memory write port (STM)
//   busy            high in every XFER and WB cycle
//   done            one-cycle pulse in the WB cycle
// -----------------------------------------------------------------------------
module reglist_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_load,
    input  logic              up,
    input  logic              pre,
    input  logic              writeback,
    input  logic [3:0]        base_reg,
    input  logic [DATA_W-1:0] base,
    input  logic [15:0]       reglist,
    input  logic [DATA_W-1:0] rf_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        rf_ra,
    output logic              rf_we,
    output logic [3:0]        rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              pc_we,
    output logic [DATA_W-1:0] pc_wd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] WORD = ADDR_W'(4);

    state_t            state;
    logic [15:0]       pend;      // registers still to transfer
    logic              ld_r;      // captured is_load
    logic              wbwe_r;    // WB cycle must write the base register
    logic [3:0]        breg_r;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] final_r;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                r = 4'(i);
            end
        end
        return r;
    endfunction

    // Start address and final base derived from the launch inputs.
    logic [4:0]        n_c;
    logic [ADDR_W-1:0] step_c;
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] start_addr_c;
    logic [ADDR_W-1:0] final_c;
    logic              wbwe_c;

    always_comb begin
        n_c    = popcount16(reglist);
        step_c = ADDR_W'(n_c) << 2;
        base_a = ADDR_W'(base);
        if (up) begin
            start_addr_c = pre ? (base_a + WORD) : base_a;
            final_c      = base_a + step_c;
        end else begin
            // Decrementing modes still place the lowest register at the lowest
            // address, so the walk starts at the bottom of the block.
            start_addr_c = pre ? (base_a - step_c) : (base_a - step_c + WORD);
            final_c      = base_a - step_c;
        end
        // A loaded base wins over writeback; an empty list leaves the base
        // untouched, so no write is issued at all.
        wbwe_c = writeback && (reglist != 16'd0) && !(is_load && reglist[base_reg]);
    end

    logic [3:0] cur;
    logic       last;

    assign cur  = lowest_set(pend);
    assign last = ((pend & (pend - 16'd1)) == 16'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            pend   <= 16'd0;
            ld_r   <= 1'b0;
            wbwe_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ld_r   <= is_load;
                        wbwe_r <= wbwe_c;
                        pend   <= reglist;
                        state  <= (reglist != 16'd0) ? XFER : WB;
                    end
                end
                XFER: begin
                    pend <= pend & ~(16'd1 << cur);
                    if (last) begin
                        state <= WB;
                    end
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Address/base datapath: loaded at start, stepped once per XFER cycle.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            addr    <= start_addr_c;
            final_r <= DATA_W'(final_c);
            breg_r  <= base_reg;
        end else if (state == XFER) begin
            addr <= addr + WORD;
        end
    end

    // Output decode: everything is gated by state so IDLE drives all zeros.
    logic st_act;
    logic ld_act;
    logic wb_we;
    logic is_pc;

    assign st_act = (state == XFER) && !ld_r;
    assign ld_act = (state == XFER) && ld_r;
    assign wb_we  = (state == WB) && wbwe_r;
    assign is_pc  = (cur == 4'd15);

    assign busy      = (state != IDLE);
    assign done      = (state == WB);
    assign mem_addr  = (state == XFER) ? addr : '0;
    assign mem_we    = st_act;
    assign mem_wdata = st_act ? rf_rd : '0;
    assign rf_ra     = st_act ? cur : 4'd0;
    assign rf_we     = (ld_act && !is_pc) || wb_we;
    assign rf_wa     = ld_act ? cur : (wb_we ? breg_r : 4'd0);
    assign rf_wd     = ld_act ? mem_rdata : (wb_we ? final_r : '0);
    assign pc_we     = ld_act && is_pc;
    assign pc_wd     = (ld_act && is_pc) ? mem_rdata : '0;

endmodule
